// File: rtl/iiitb_tlc_sensor.sv
// Farm-road vehicle detector: debounces arrive/depart loop pulses, keeps a queue count, raises sensor.
// Latency: DEB_CYCLES+3 clk edges from first raw-high sample to queue_cnt/state update.
// Backpressure: none; inputs free-run, arrivals at saturation are dropped and flagged in overflow.
// Build option: define TLC_SENSOR_STATS_EN to add the served_cnt and max_queue outputs.
module iiitb_tlc_sensor #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4,
    parameter int THRESHOLD  = 3,
    parameter int MAX_WAIT   = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_raw,
    input  logic             depart_raw,
    input  logic [2:0]       light_farm,
    output logic             sensor,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             overflow
`ifdef TLC_SENSOR_STATS_EN
    ,
    output logic [15:0]      served_cnt,
    output logic [CNT_W-1:0] max_queue
`endif
);

    localparam int SW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] Q_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] Q_THR     = CNT_W'(THRESHOLD);
    localparam logic [SW-1:0]    STAB_DONE = SW'(DEB_CYCLES);
    localparam logic [TW-1:0]    WAIT_LAST = TW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_REQ   = 2'd2,
        S_SERVE = 2'd3
    } state_t;

    // Bit 0 carries the arrival loop, bit 1 the departure loop.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    flip;
    logic [1:0]    rise;
    logic [SW-1:0] stab [2];

    logic             arr_evt;
    logic             dep_evt;
    logic             dep_ok;
    logic             light_go;
    logic             light_green;
    logic             light_red;
    logic [CNT_W-1:0] q_nxt;
    logic             ovf_nxt;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;

    assign raw = {depart_raw, arrive_raw};

    // A flip fires in the cycle the stable-disagreement run completes, so the
    // queue sees the event on the same edge the debounced level changes.
    assign flip = (sync2 ^ deb) & {(stab[1] == STAB_DONE), (stab[0] == STAB_DONE)};
    assign rise = flip & sync2;

    // Two-flop synchronizers followed by per-input stability counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            stab[0] <= '0;
            stab[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (flip[i]) begin
                    deb[i]  <= sync2[i];
                    stab[i] <= '0;
                end else if (sync2[i] != deb[i]) begin
                    stab[i] <= stab[i] + SW'(1);
                end else begin
                    stab[i] <= '0;
                end
            end
        end
    end

    assign arr_evt     = rise[0];
    assign dep_evt     = rise[1];
    // Illegal light codes fall through to "not green/yellow", i.e. treated as RED.
    assign light_green = (light_farm == 3'b001);
    assign light_go    = light_green || (light_farm == 3'b010);
    assign light_red   = !light_go;
    assign dep_ok      = dep_evt && light_go && (queue_cnt != '0);

    // Next queue count and sticky overflow from this cycle's events.
    always_comb begin
        q_nxt   = queue_cnt;
        ovf_nxt = overflow;
        if (arr_evt && !dep_ok) begin
            if (queue_cnt == Q_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                q_nxt = queue_cnt + CNT_W'(1);
            end
        end else if (dep_ok && !arr_evt) begin
            q_nxt = queue_cnt - CNT_W'(1);
        end
    end

    // Queue, overflow, state and wait timer all move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            queue_cnt <= '0;
            overflow  <= 1'b0;
            state     <= S_IDLE;
            timer     <= '0;
        end else begin
            queue_cnt <= q_nxt;
            overflow  <= ovf_nxt;
            state     <= state_nxt;
            timer     <= timer_nxt;
        end
    end

    // Request FSM, steered by the next queue count; timer clears on any exit from WAIT.
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        case (state)
            S_IDLE: begin
                if (q_nxt >= Q_THR) begin
                    state_nxt = S_REQ;
                end else if (q_nxt != '0) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (q_nxt == '0) begin
                    state_nxt = S_IDLE;
                end else if ((q_nxt >= Q_THR) || (timer == WAIT_LAST)) begin
                    state_nxt = S_REQ;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_REQ: begin
                if (q_nxt == '0) begin
                    state_nxt = S_IDLE;
                end else if (light_green) begin
                    state_nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                if (q_nxt == '0) begin
                    state_nxt = S_IDLE;
                end else if (light_red) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sensor = (state == S_REQ) || (state == S_SERVE);

`ifdef TLC_SENSOR_STATS_EN
    // Service statistics tracked alongside the queue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            served_cnt <= '0;
            max_queue  <= '0;
        end else begin
            if (dep_ok) begin
                served_cnt <= served_cnt + 16'd1;
            end
            if (q_nxt > max_queue) begin
                max_queue <= q_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iiitb_tlc_sensor.sv
// Bench for iiitb_tlc_sensor: queue model feeds expected counts to a scoreboard,
// a negedge monitor pops and compares whenever queue_cnt moves.
// Timing of sensor edges is checked directly against the stimulus cycle count.
`timescale 1ns/1ps
module tb_iiitb_tlc_sensor;

    localparam int DEB_CYCLES = 4;
    localparam int CNT_W      = 4;
    localparam int THRESHOLD  = 3;
    localparam int MAX_WAIT   = 200;
    localparam int Q_SAT      = (1 << CNT_W) - 1;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             arrive_raw = 1'b0;
    logic             depart_raw = 1'b0;
    logic [2:0]       light_farm = 3'b100;
    logic             sensor;
    logic [CNT_W-1:0] queue_cnt;
    logic             overflow;
`ifdef TLC_SENSOR_STATS_EN
    logic [15:0]      served_cnt;
    logic [CNT_W-1:0] max_queue;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int model_q  = 0;
    int model_ovf = 0;
    int model_served = 0;
    int model_peak = 0;
    int last_q   = 0;

    always #5 clk = ~clk;

    iiitb_tlc_sensor #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .THRESHOLD  (THRESHOLD),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arrive_raw (arrive_raw),
        .depart_raw (depart_raw),
        .light_farm (light_farm),
        .sensor     (sensor),
        .queue_cnt  (queue_cnt),
        .overflow   (overflow)
`ifdef TLC_SENSOR_STATS_EN
        ,
        .served_cnt (served_cnt),
        .max_queue  (max_queue)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every observed queue_cnt change must match the next expected value.
    always @(negedge clk) begin
        if (rst) begin
            last_q = 0;
        end else if (int'(queue_cnt) != last_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_queue_change", int'(queue_cnt), last_q);
            end else begin
                check("queue_cnt", int'(queue_cnt), exp_q.pop_front());
            end
            last_q = int'(queue_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference queue behaviour for one debounced event slot.
    task automatic model_event(input bit arr, input bit dep, input logic [2:0] lf);
        bit ok;
        ok = dep && ((lf == GREEN) || (lf == YELLOW)) && (model_q > 0);
        if (ok) model_served++;
        if (arr && ok) return;
        if (arr) begin
            if (model_q == Q_SAT) begin
                model_ovf = 1;
            end else begin
                model_q++;
                exp_q.push_back(model_q);
            end
        end else if (ok) begin
            model_q--;
            exp_q.push_back(model_q);
        end
        if (model_q > model_peak) model_peak = model_q;
    endtask

    // Raw pulse sampled high on edges 1..hi; records sensor/queue around obs_edge.
    task automatic pulse(input bit arr, input bit dep, input int hi, input int lo,
                         input int obs_edge, output int s_before, output int s_at,
                         output int q_at);
        s_before = 0;
        s_at     = 0;
        q_at     = 0;
        if (hi >= DEB_CYCLES + 1) model_event(arr, dep, light_farm);
        arrive_raw = arr;
        depart_raw = dep;
        for (int t = 1; t <= hi + lo; t++) begin
            cyc();
            if (t == obs_edge - 1) s_before = int'(sensor);
            if (t == obs_edge) begin
                s_at = int'(sensor);
                q_at = int'(queue_cnt);
            end
            if (t >= hi) begin
                arrive_raw = 1'b0;
                depart_raw = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        arrive_raw = 1'b0;
        depart_raw = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        model_q = 0;
        model_ovf = 0;
        model_served = 0;
        model_peak = 0;
        exp_q.delete();
    endtask

    initial begin
        int sb, sa, qa;
        int t_q1, t_s;

        // Reset held with arrive_raw high, then first arrival latency.
        rst = 1'b1;
        arrive_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_sensor", int'(sensor), 0);
            check("rst_queue", int'(queue_cnt), 0);
            check("rst_overflow", int'(overflow), 0);
        end
        rst = 1'b0;
        model_event(1'b1, 1'b0, light_farm);
        for (int t = 1; t <= 7; t++) begin
            cyc();
            if (t == 6) check("latency_edge6_queue", int'(queue_cnt), 0);
            if (t == 7) check("latency_edge7_queue", int'(queue_cnt), 1);
        end
        arrive_raw = 1'b0;
        repeat (20) cyc();

        // Short glitches never register.
        do_reset();
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 4, 10, 0, sb, sa, qa);
        check("glitch_queue", int'(queue_cnt), 0);

        // Single arrival under RED waits MAX_WAIT cycles before requesting.
        light_farm = RED;
        model_event(1'b1, 1'b0, light_farm);
        arrive_raw = 1'b1;
        t_q1 = -1;
        t_s  = -1;
        for (int t = 1; t <= 400 && t_s < 0; t++) begin
            cyc();
            if (t >= 8) arrive_raw = 1'b0;
            if (t_q1 < 0 && queue_cnt == 1) t_q1 = t;
            if (t_s < 0 && sensor) t_s = t;
        end
        arrive_raw = 1'b0;
        check("wait_arrival_edge", t_q1, 7);
        check("wait_sensor_delay", t_s - t_q1, MAX_WAIT);
        pulse(1'b0, 1'b1, 8, 20, 0, sb, sa, qa);
        check("red_depart_ignored", int'(queue_cnt), 1);
        light_farm = 3'b110;
        pulse(1'b0, 1'b1, 8, 20, 0, sb, sa, qa);
        check("illegal_light_depart_ignored", int'(queue_cnt), 1);
        check("illegal_light_sensor_held", int'(sensor), 1);
        light_farm = RED;

        // Threshold: sensor rises on the edge the queue reaches THRESHOLD.
        do_reset();
        pulse(1'b1, 1'b0, 8, 20, 0, sb, sa, qa);
        pulse(1'b1, 1'b0, 8, 20, 0, sb, sa, qa);
        check("below_threshold_sensor", int'(sensor), 0);
        pulse(1'b1, 1'b0, 8, 20, 7, sb, sa, qa);
        check("threshold_queue", qa, THRESHOLD);
        check("threshold_sensor_before", sb, 0);
        check("threshold_sensor_at", sa, 1);

        // Serve under GREEN down to empty; sensor falls with the last departure.
        light_farm = GREEN;
        cyc();
        check("serve_sensor", int'(sensor), 1);
        pulse(1'b0, 1'b1, 8, 20, 0, sb, sa, qa);
        pulse(1'b0, 1'b1, 8, 20, 0, sb, sa, qa);
        check("serve_partial_sensor", int'(sensor), 1);
        pulse(1'b0, 1'b1, 8, 20, 7, sb, sa, qa);
        check("empty_queue", qa, 0);
        check("empty_sensor_before", sb, 1);
        check("empty_sensor_at", sa, 0);
        pulse(1'b1, 1'b0, 8, 20, 0, sb, sa, qa);
        pulse(1'b1, 1'b1, 8, 20, 0, sb, sa, qa);
        check("simultaneous_queue", int'(queue_cnt), 1);
        check("simultaneous_sensor", int'(sensor), 0);

        // Saturation, overflow, then SERVE -> REQ with sensor held.
        do_reset();
        light_farm = RED;
        for (int i = 0; i < 16; i++) pulse(1'b1, 1'b0, 8, 20, 0, sb, sa, qa);
        check("sat_queue", int'(queue_cnt), model_q);
        check("sat_overflow", int'(overflow), model_ovf);
        check("sat_sensor", int'(sensor), 1);
        light_farm = GREEN;
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 8, 20, 0, sb, sa, qa);
        light_farm = YELLOW;
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 8, 20, 0, sb, sa, qa);
        check("drained_queue", int'(queue_cnt), 5);
        check("drained_sensor", int'(sensor), 1);
        light_farm = RED;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("serve_to_req_sensor", int'(sensor), 1);
        end
        check("overflow_sticky", int'(overflow), 1);
`ifdef TLC_SENSOR_STATS_EN
        check("stats_max_queue", int'(max_queue), model_peak);
        check("stats_served_cnt", int'(served_cnt), model_served);
`endif

        // Reset mid-operation clears everything.
        rst = 1'b1;
        cyc();
        check("midrst_queue", int'(queue_cnt), 0);
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_sensor", int'(sensor), 0);
        rst = 1'b0;
        model_q = 0;
        model_ovf = 0;
        exp_q.delete();
        repeat (20) cyc();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
